fetch_queue: RTL and testbench

Instruction fetch front end that sits directly upstream of decode.
- Owns the architectural fetch PC and drives the instruction-memory read port (word address).
- Tracks requests in flight across a fixed memory latency and buffers the returned instructions with their PCs in a small circular queue.
- Presents the queue head to decode with valid/stall handshaking, and discards all wrong-path state on a redirect (flush) from execute.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_fifo.sv | 72 +++++++
 rtl/fetch_queue.sv | 129 ++++++++++++
 tb/tb_fetch_queue.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned PC_W    = 16;
  localparam int unsigned ENTRY_W = PC_W + INSTR_W;

  localparam logic [PC_W-1:0] PC_STEP = 16'd2;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry circular buffer of fetch entries; head is read combinationally.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_data,
  input  logic               pop,
  output logic [ENTRY_W-1:0] head,
  output logic [CNT_W-1:0]   count,
  output logic               full,
  output logic               empty
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers wrap for free because DEPTH is a power of two.
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && do_push) begin
      mem_q[wr_ptr_q] <= fetch_entry_t'(push_data);
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: PC, credit-limited issue, in-flight pipe and decode-facing queue.
// Define FETCH_BYPASS_EN to let a return reach out_* in its arrival cycle when the queue is empty.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned MEM_LATENCY = 1,
  parameter logic [15:0] RESET_PC    = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [14:0] mem_raddr,
  input  logic [15:0] mem_rdata,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        halt,
  input  logic        d_stall,
  output logic        out_valid,
  output logic [15:0] out_pc,
  output logic [15:0] out_instruction
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned OCC_W = CNT_W + 1;
  localparam int unsigned IF_W  = $clog2(MEM_LATENCY + 1);

`ifdef FETCH_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [PC_W-1:0]  pc_q, pc_d;
  logic             pipe_valid_q [MEM_LATENCY];
  logic [PC_W-1:0]  pipe_pc_q    [MEM_LATENCY];
  logic [IF_W-1:0]  inflight;
  logic [OCC_W-1:0] occupancy;
  logic             issue;

  fetch_entry_t     fifo_head, ret_entry, out_entry;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic             ret_valid, bypass_hit;

  assign mem_raddr = pc_q[15:1];

  // Credits: never have more entries outstanding than the queue can hold.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < MEM_LATENCY; i++) begin
      inflight = inflight + IF_W'(pipe_valid_q[i]);
    end
    occupancy = OCC_W'(fifo_count) + OCC_W'(inflight);
    issue     = !rst && !redirect && !halt && (occupancy < OCC_W'(DEPTH));
  end

  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      pc_d = redirect_pc & 16'hFFFE;
    end else if (issue) begin
      pc_d = pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || redirect) begin
      for (int i = 0; i < MEM_LATENCY; i++) begin
        pipe_valid_q[i] <= 1'b0;
        pipe_pc_q[i]    <= '0;
      end
    end else begin
      pipe_valid_q[0] <= issue;
      pipe_pc_q[0]    <= pc_q;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        pipe_valid_q[i] <= pipe_valid_q[i-1];
        pipe_pc_q[i]    <= pipe_pc_q[i-1];
      end
    end
  end

  always_comb begin
    ret_valid       = pipe_valid_q[MEM_LATENCY-1];
    ret_entry.pc    = pipe_pc_q[MEM_LATENCY-1];
    ret_entry.instr = mem_rdata;
    bypass_hit      = BYPASS && fifo_empty && ret_valid && !redirect && !rst;

    out_entry = '0;
    if (!fifo_empty) begin
      out_entry = fifo_head;
    end else if (bypass_hit) begin
      out_entry = ret_entry;
    end
    out_valid = !fifo_empty || bypass_hit;

    fifo_pop  = !fifo_empty && !d_stall;
    // A bypassed return that decode accepts is never stored.
    fifo_push = ret_valid && !rst && !redirect && !(bypass_hit && !d_stall);
  end

  assign out_pc          = out_entry.pc;
  assign out_instruction = out_entry.instr;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (fifo_push),
    .push_data (ret_entry),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  no_overflow_a: assert property (@(posedge clk) disable iff (rst) !(fifo_push && fifo_full));

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH=4, MEM_LATENCY=LAT).
module tb_fetch_queue;

  localparam int unsigned LAT = 2;
`ifdef FETCH_BYPASS_EN
  localparam int FIRST = LAT;
`else
  localparam int FIRST = LAT + 1;
`endif

  logic        clk;
  logic        rst;
  logic [14:0] mem_raddr;
  logic [15:0] mem_rdata;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halt;
  logic        d_stall;
  logic        out_valid;
  logic [15:0] out_pc;
  logic [15:0] out_instruction;

  int total = 0;
  int bad   = 0;

  fetch_queue #(
    .DEPTH       (4),
    .MEM_LATENCY (LAT),
    .RESET_PC    (16'h0000)
  ) u_dut (
    .clk             (clk),
    .rst             (rst),
    .mem_raddr       (mem_raddr),
    .mem_rdata       (mem_rdata),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .halt            (halt),
    .d_stall         (d_stall),
    .out_valid       (out_valid),
    .out_pc          (out_pc),
    .out_instruction (out_instruction)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: word n holds 16'h8000 | n, returned LAT cycles after its address.
  logic [14:0] addr_pipe [LAT];
  always @(posedge clk) begin
    addr_pipe[0] <= mem_raddr;
    for (int i = 1; i < LAT; i++) addr_pipe[i] <= addr_pipe[i-1];
  end
  assign mem_rdata = 16'h8000 | {1'b0, addr_pipe[LAT-1]};

  function automatic logic [15:0] mem_word(input logic [15:0] p);
    return 16'h8000 | {1'b0, p[15:1]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; halt = 1'b0; d_stall = 1'b0;
    step(); step();
    for (int k = 0; k < 3; k++) begin
      #1;
      total++;
      if (out_valid !== 1'b0 || out_pc !== 16'h0000 || out_instruction !== 16'h0000) begin
        bad++;
        $display("FAIL reset_out k=%0d: got v=%b pc=%h ins=%h want v=0 pc=0000 ins=0000",
                 k, out_valid, out_pc, out_instruction);
      end
      total++;
      if (mem_raddr !== 15'h0000) begin
        bad++;
        $display("FAIL reset_raddr k=%0d: got %h want 0000", k, mem_raddr);
      end
      step();
    end
  endtask

  // Start an old path at 0x0200, reset mid-flight, then check the clean stream from 0.
  task automatic test_stream();
    logic [15:0] exp_pc;
    rst = 1'b0; d_stall = 1'b0; halt = 1'b0;
    redirect = 1'b1; redirect_pc = 16'h0200;
    step(); redirect = 1'b0;
    step(); step();
    rst = 1'b1; step(); rst = 1'b0;
    for (int k = 0; k < FIRST + 6; k++) begin
      #1;
      if (k == 0) begin
        total++;
        if (mem_raddr !== 15'h0000) begin
          bad++;
          $display("FAIL stream_raddr0: got %h want 0000", mem_raddr);
        end
      end
      if (k < FIRST) begin
        total++;
        if (out_valid !== 1'b0) begin
          bad++;
          $display("FAIL stream_early k=%0d: got valid=%b want 0", k, out_valid);
        end
      end else begin
        exp_pc = 16'(2 * (k - FIRST));
        total++;
        if (out_valid !== 1'b1 || out_pc !== exp_pc || out_instruction !== mem_word(exp_pc)) begin
          bad++;
          $display("FAIL stream k=%0d: got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h",
                   k, out_valid, out_pc, out_instruction, exp_pc, mem_word(exp_pc));
        end
      end
      step();
    end
  endtask

  task automatic test_stall();
    logic [14:0] exp_addr;
    logic [15:0] exp_pc;
    int seen;
    rst = 1'b1; d_stall = 1'b1; halt = 1'b0; redirect = 1'b0;
    step(); rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #1;
      exp_addr = (k < 4) ? 15'(k) : 15'd4;
      total++;
      if (mem_raddr !== exp_addr) begin
        bad++;
        $display("FAIL stall_credit k=%0d: got %h want %h", k, mem_raddr, exp_addr);
      end
      if (k >= FIRST) begin
        total++;
        if (out_valid !== 1'b1 || out_pc !== 16'h0000) begin
          bad++;
          $display("FAIL stall_head k=%0d: got v=%b pc=%h want v=1 pc=0000", k, out_valid, out_pc);
        end
      end
      step();
    end
    d_stall = 1'b0;
    exp_pc = 16'h0000;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (out_valid === 1'b1) begin
        total++;
        if (out_pc !== exp_pc || out_instruction !== mem_word(exp_pc)) begin
          bad++;
          $display("FAIL stall_drain k=%0d: got pc=%h ins=%h want pc=%h ins=%h",
                   k, out_pc, out_instruction, exp_pc, mem_word(exp_pc));
        end
        exp_pc = exp_pc + 16'd2;
        seen++;
      end
      step();
    end
    total++;
    if (seen < 8) begin
      bad++;
      $display("FAIL stall_drain_count: got %0d want >= 8", seen);
    end
  endtask

  // Redirect with d_stall high and a return landing: once mid-fill, once with a full queue.
  task automatic test_redirect();
    logic [15:0] targets [2];
    int          waits   [2];
    logic [15:0] base, exp_pc;
    targets = '{16'h0031, 16'h1235};
    waits   = '{LAT + 2, 9};
    for (int s = 0; s < 2; s++) begin
      rst = 1'b1; d_stall = 1'b1; halt = 1'b0; redirect = 1'b0;
      step(); rst = 1'b0;
      for (int k = 0; k < waits[s]; k++) step();
      #1;
      total++;
      if (out_valid !== 1'b1) begin
        bad++;
        $display("FAIL redir_pre s=%0d: got valid=%b want 1", s, out_valid);
      end
      redirect = 1'b1; redirect_pc = targets[s];
      step();
      redirect = 1'b0; d_stall = 1'b0;
      base = targets[s] & 16'hFFFE;
      for (int j = 0; j < FIRST + 4; j++) begin
        #1;
        if (j == 0) begin
          total++;
          if (mem_raddr !== base[15:1]) begin
            bad++;
            $display("FAIL redir_raddr s=%0d: got %h want %h", s, mem_raddr, base[15:1]);
          end
        end
        if (j < FIRST) begin
          total++;
          if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL redir_flush s=%0d j=%0d: got valid=%b pc=%h want 0",
                     s, j, out_valid, out_pc);
          end
        end else begin
          exp_pc = base + 16'(2 * (j - FIRST));
          total++;
          if (out_valid !== 1'b1 || out_pc !== exp_pc || out_instruction !== mem_word(exp_pc)) begin
            bad++;
            $display("FAIL redir_path s=%0d j=%0d: got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h",
                     s, j, out_valid, out_pc, out_instruction, exp_pc, mem_word(exp_pc));
          end
        end
        step();
      end
    end
  endtask

  task automatic test_wrap();
    logic [15:0] wrap_pc  [3];
    logic [15:0] wrap_ins [3];
    wrap_pc  = '{16'hFFFC, 16'hFFFE, 16'h0000};
    wrap_ins = '{16'hFFFE, 16'hFFFF, 16'h8000};
    d_stall = 1'b0; halt = 1'b0;
    redirect = 1'b1; redirect_pc = 16'hFFFC;
    step(); redirect = 1'b0;
    for (int j = 0; j < FIRST + 3; j++) begin
      #1;
      if (j >= FIRST) begin
        total++;
        if (out_valid !== 1'b1 || out_pc !== wrap_pc[j-FIRST]
            || out_instruction !== wrap_ins[j-FIRST]) begin
          bad++;
          $display("FAIL wrap j=%0d: got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h",
                   j, out_valid, out_pc, out_instruction, wrap_pc[j-FIRST], wrap_ins[j-FIRST]);
        end
      end
      step();
    end
  endtask

  task automatic test_halt();
    logic [14:0] exp_addr;
    logic        exp_v;
    rst = 1'b1; d_stall = 1'b0; halt = 1'b0; redirect = 1'b0;
    step(); rst = 1'b0;
    for (int k = 0; k < FIRST + 5; k++) begin
      if (k == 2) halt = 1'b1;
      #1;
      exp_addr = (k < 2) ? 15'(k) : 15'd2;
      total++;
      if (mem_raddr !== exp_addr) begin
        bad++;
        $display("FAIL halt_raddr k=%0d: got %h want %h", k, mem_raddr, exp_addr);
      end
      exp_v = (k == FIRST) || (k == FIRST + 1);
      total++;
      if (out_valid !== exp_v || (exp_v && out_pc !== 16'(2 * (k - FIRST)))) begin
        bad++;
        $display("FAIL halt_out k=%0d: got v=%b pc=%h want v=%b pc=%h",
                 k, out_valid, out_pc, exp_v, 16'(2 * (k - FIRST)));
      end
      step();
    end
    halt = 1'b0;
    step();
    #1;
    total++;
    if (mem_raddr !== 15'd3) begin
      bad++;
      $display("FAIL halt_resume: got %h want 0003", mem_raddr);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_wrap();
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
